usb_data_buffer: RTL and testbench



---
 rtl/usb_buf_pkg.sv | 22 ++
 rtl/usb_buffer_ram.sv | 38 +++
 rtl/usb_data_buffer.sv | 167 ++++++++++++++++
 tb/tb_usb_data_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint byte buffer: AHB access-size
// encodings, the byte-count decode helper and the default buffer depth.
package usb_buf_pkg;

  localparam int USB_BUF_DEPTH = 64;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Number of bytes moved by an AHB access of the given size code.
  // The unused 2'b11 code is treated as a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_bytes = 3'd1;
      SIZE_HALF: size_to_bytes = 3'd2;
      SIZE_WORD: size_to_bytes = 3'd4;
      default:   size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_ram.sv
// DEPTH x 8 byte store for the endpoint buffer. Four-lane write port and
// four-lane combinational read port; lane k of either port addresses
// base + k modulo DEPTH, so multi-byte accesses wrap byte by byte.
module usb_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wcnt,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem_q [DEPTH];

  // Write the first wcnt lanes of wdata starting at waddr (no reset on storage).
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < wcnt) begin
          mem_q[waddr + AW'(k)] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Present the four bytes starting at raddr.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = mem_q[raddr + AW'(k)];
    end
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO between the AHB slave side (1/2/4-byte accesses) and
// the USB packet side (one byte per cycle). Owns the pointers, write/read
// arbitration, overflow/underflow detection and registered status.
// Optional feature: define USB_DATA_BUFFER_WATERMARK_EN to add the
// AF_THRESH parameter and the registered almost_full output.
//
// Strobe semantics: store_tx_data, get_rx_data, store_rx_packet_data and
// get_tx_packet_data are single-cycle data-phase qualifiers with no
// back-pressure. Each high cycle is one access request; an access that
// cannot be honoured is dropped in full and reported by a one-cycle
// buffer_err pulse in the following cycle. Read data (rx_data,
// tx_packet_data) is a combinational peek valid in the strobe cycle.
module usb_data_buffer
  import usb_buf_pkg::*;
#(
`ifdef USB_DATA_BUFFER_WATERMARK_EN
  parameter int AF_THRESH = 56,
`endif
  parameter int DEPTH = USB_BUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_tx_data,
  input  logic [1:0]       tx_size,
  input  logic [31:0]      hwdata,
  input  logic             get_rx_data,
  input  logic [1:0]       rx_size,
  output logic [31:0]      rx_data,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  input  logic             flush,
  input  logic             clear,
  output logic [PTR_W-1:0] buffer_occupancy,
  output logic             empty,
  output logic             full,
`ifdef USB_DATA_BUFFER_WATERMARK_EN
  output logic             almost_full,
`endif
  output logic             buffer_err
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] occ_q, occ_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic             wr_req, rd_req;
  logic [2:0]       wr_cnt, rd_cnt, rx_peek_cnt;
  logic [31:0]      wr_data;
  logic             wr_ok, rd_ok, wr_en;
  logic [PTR_W:0]   occ_after;
  logic [31:0]      ram_rdata;

  // Arbitrate pushes/pops, detect illegal accesses, compute next pointers/status.
  always_comb begin
    wr_req    = store_rx_packet_data | store_tx_data;
    wr_cnt    = store_rx_packet_data ? 3'd1 : size_to_bytes(tx_size);
    wr_data   = store_rx_packet_data ? {24'h0, rx_packet_data} : hwdata;
    rd_req    = get_tx_packet_data | get_rx_data;
    rd_cnt    = get_tx_packet_data ? 3'd1 : size_to_bytes(rx_size);

    // A pop may only consume bytes already held before this cycle.
    rd_ok     = rd_req && (PTR_W'(rd_cnt) <= occ_q);
    // The push must fit after the (successful) pop of the same cycle.
    occ_after = (PTR_W+1)'(occ_q) - (PTR_W+1)'(rd_ok ? rd_cnt : 3'd0)
              + (PTR_W+1)'(wr_cnt);
    wr_ok     = wr_req && (occ_after <= (PTR_W+1)'(DEPTH));

    err_d     = (store_rx_packet_data & store_tx_data)
              | (get_tx_packet_data & get_rx_data)
              | (wr_req & ~wr_ok)
              | (rd_req & ~rd_ok);
    wr_en     = wr_ok;
    wr_ptr_d  = wr_ptr_q + (wr_ok ? PTR_W'(wr_cnt) : '0);
    rd_ptr_d  = rd_ptr_q + (rd_ok ? PTR_W'(rd_cnt) : '0);

    // Flush/clear discard everything and silence all strobes of the cycle.
    if (flush || clear) begin
      err_d    = 1'b0;
      wr_en    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    occ_d   = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
              (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
  end

  // Pointer and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  usb_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wcnt  (wr_cnt),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Zero-latency head peeks; lanes beyond the request size or the held bytes read 0.
  always_comb begin
    rx_peek_cnt    = size_to_bytes(rx_size);
    rx_data        = '0;
    tx_packet_data = empty_q ? 8'h00 : ram_rdata[7:0];
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) < rx_peek_cnt) && (PTR_W'(k) < occ_q)) begin
        rx_data[8*k +: 8] = ram_rdata[8*k +: 8];
      end
    end
  end

  assign buffer_occupancy = occ_q;
  assign empty            = empty_q;
  assign full             = full_q;
  assign buffer_err       = err_q;

`ifdef USB_DATA_BUFFER_WATERMARK_EN
  logic almost_full_q, almost_full_d;

  // Watermark flag follows the next-cycle occupancy.
  always_comb begin
    almost_full_d = (occ_d >= PTR_W'(AF_THRESH));
  end

  // Registered watermark flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (full/overflow, wrap-around,
// reset during traffic and the optional watermark).
module tb_usb_data_buffer;

  logic        clk;
  logic        n_rst;
  logic        store_tx_data;
  logic [1:0]  tx_size;
  logic [31:0] hwdata;
  logic        get_rx_data;
  logic [1:0]  rx_size;
  logic [31:0] rx_data;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic        flush;
  logic        clear;
  logic [6:0]  buffer_occupancy;
  logic        empty;
  logic        full;
  logic        buffer_err;
`ifdef USB_DATA_BUFFER_WATERMARK_EN
  logic        almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .store_tx_data        (store_tx_data),
    .tx_size              (tx_size),
    .hwdata               (hwdata),
    .get_rx_data          (get_rx_data),
    .rx_size              (rx_size),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .flush                (flush),
    .clear                (clear),
    .buffer_occupancy     (buffer_occupancy),
    .empty                (empty),
    .full                 (full),
`ifdef USB_DATA_BUFFER_WATERMARK_EN
    .almost_full          (almost_full),
`endif
    .buffer_err           (buffer_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        st;
    logic [1:0]  tsz;
    logic [31:0] hw;
    logic        gr;
    logic [1:0]  rsz;
    logic        su;
    logic [7:0]  ub;
    logic        gu;
    logic        fl;
    logic        cl;
    logic [31:0] e_rx;
    logic [7:0]  e_tx;
    logic [6:0]  e_occ;
    logic        e_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic st, input logic [1:0] tsz, input logic [31:0] hw,
                              input logic gr, input logic [1:0] rsz,
                              input logic su, input logic [7:0] ub, input logic gu,
                              input logic fl, input logic cl,
                              input logic [31:0] e_rx, input logic [7:0] e_tx,
                              input logic [6:0] e_occ, input logic e_err);
    vec_t v;
    v.st = st; v.tsz = tsz; v.hw = hw; v.gr = gr; v.rsz = rsz;
    v.su = su; v.ub = ub; v.gu = gu; v.fl = fl; v.cl = cl;
    v.e_rx = e_rx; v.e_tx = e_tx; v.e_occ = e_occ; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input logic [6:0] e_occ, input logic e_err);
    chk({nm, "_occ"},   32'(buffer_occupancy), 32'(e_occ));
    chk({nm, "_empty"}, 32'(empty),            32'(e_occ == 7'd0));
    chk({nm, "_full"},  32'(full),             32'(e_occ == 7'd64));
    chk({nm, "_err"},   32'(buffer_err),       32'(e_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    store_tx_data        = 1'b0;
    tx_size              = 2'b00;
    hwdata               = 32'h0;
    get_rx_data          = 1'b0;
    rx_size              = 2'b10;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h0;
    get_tx_packet_data   = 1'b0;
    flush                = 1'b0;
    clear                = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    store_tx_data        = v.st;
    tx_size              = v.tsz;
    hwdata               = v.hw;
    get_rx_data          = v.gr;
    rx_size              = v.rsz;
    store_rx_packet_data = v.su;
    rx_packet_data       = v.ub;
    get_tx_packet_data   = v.gu;
    flush                = v.fl;
    clear                = v.cl;
    #1;
    chk($sformatf("vec%0d_rx_data", idx), rx_data, v.e_rx);
    chk($sformatf("vec%0d_tx_pkt", idx), 32'(tx_packet_data), 32'(v.e_tx));
    tick();
    chk_status($sformatf("vec%0d", idx), v.e_occ, v.e_err);
  endtask

  task automatic usb_push(input logic [7:0] b);
    @(negedge clk);
    idle_inputs();
    store_rx_packet_data = 1'b1;
    rx_packet_data       = b;
    exp_q.push_back(b);
    tick();
  endtask

  task automatic usb_pop_chk(input string nm);
    logic [7:0] e;
    @(negedge clk);
    idle_inputs();
    get_tx_packet_data = 1'b1;
    e = exp_q.pop_front();
    #1;
    chk(nm, 32'(tx_packet_data), 32'(e));
    tick();
  endtask

  task automatic do_flush();
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    exp_q.delete();
    tick();
  endtask

  // ---------------- test body ----------------
  initial begin
    idle_inputs();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset", 7'd0, 1'b0);
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_tx_pkt", 32'(tx_packet_data), 32'h0);
`ifdef USB_DATA_BUFFER_WATERMARK_EN
    chk("reset_almost_full", 32'(almost_full), 32'h0);
`endif
    @(negedge clk);
    n_rst = 1'b1;

    //          st tsz hw            gr rsz su ub     gu fl cl  e_rx          e_tx   occ err
    vt.push_back(mk(1, 2, 32'hDDCCBBAA, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'hDDCCBBAA, 8'hAA, 3, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'h00DDCCBB, 8'hBB, 2, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'h0000DDCC, 8'hCC, 1, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'h000000DD, 8'hDD, 0, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 0, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'h00000000, 8'h00, 0, 1));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 0, 0));
    vt.push_back(mk(1, 2, 32'h44332211, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 0, 0, 8'h00, 0, 0, 0, 32'h00000011, 8'h11, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 1, 0, 8'h00, 0, 0, 0, 32'h00002211, 8'h11, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        1, 1, 0, 8'h00, 0, 0, 0, 32'h00002211, 8'h11, 2, 0));
    vt.push_back(mk(0, 2, 32'h0,        1, 2, 0, 8'h00, 0, 0, 0, 32'h00004433, 8'h33, 2, 1));
    vt.push_back(mk(0, 2, 32'h0,        1, 1, 0, 8'h00, 0, 0, 0, 32'h00004433, 8'h33, 0, 0));
    vt.push_back(mk(1, 3, 32'h0D0C0B0A, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        1, 3, 0, 8'h00, 0, 0, 0, 32'h0D0C0B0A, 8'h0A, 0, 0));
    vt.push_back(mk(1, 2, 32'h77665544, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 4, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 1, 0, 0, 32'h77665544, 8'h44, 3, 0));
    vt.push_back(mk(0, 2, 32'h0,        1, 2, 0, 8'h00, 0, 0, 0, 32'h00776655, 8'h55, 3, 1));
    vt.push_back(mk(1, 1, 32'h00009988, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00776655, 8'h55, 5, 0));
    vt.push_back(mk(1, 1, 32'h0000BBAA, 0, 2, 0, 8'h00, 1, 0, 0, 32'h88776655, 8'h55, 6, 0));
    vt.push_back(mk(1, 2, 32'h11111111, 0, 2, 1, 8'hEE, 0, 0, 0, 32'h99887766, 8'h66, 7, 1));
    vt.push_back(mk(0, 2, 32'h0,        1, 0, 0, 8'h00, 1, 0, 0, 32'h00000066, 8'h66, 6, 1));
    vt.push_back(mk(0, 2, 32'h0,        1, 2, 0, 8'h00, 0, 0, 0, 32'hAA998877, 8'h77, 2, 0));
    vt.push_back(mk(0, 2, 32'h0,        1, 1, 0, 8'h00, 0, 0, 0, 32'h0000EEBB, 8'hBB, 0, 0));
    vt.push_back(mk(0, 2, 32'h0,        0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 32'h0000005A, 1, 0, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 1, 1));
    vt.push_back(mk(0, 2, 32'h0,        1, 0, 0, 8'h00, 0, 0, 0, 32'h0000005A, 8'h5A, 0, 0));
    vt.push_back(mk(1, 2, 32'h01020304, 0, 2, 0, 8'h00, 0, 0, 0, 32'h00000000, 8'h00, 4, 0));
    vt.push_back(mk(1, 2, 32'hFFFFFFFF, 0, 2, 0, 8'h00, 0, 0, 1, 32'h01020304, 8'h04, 0, 0));
    vt.push_back(mk(1, 2, 32'hFFFFFFFF, 1, 2, 1, 8'h12, 1, 1, 0, 32'h00000000, 8'h00, 0, 0));

    foreach (vt[i]) run_vec(vt[i], i);

    // ---- fill to full, overflow, push+pop at full ----
    exp_q.delete();
    for (int i = 0; i < 64; i++) usb_push(8'(i));
    chk_status("fill64", 7'd64, 1'b0);

    @(negedge clk);
    idle_inputs();
    store_tx_data = 1'b1; tx_size = 2'b00; hwdata = 32'h00000055;
    tick();
    chk_status("ovf_push", 7'd64, 1'b1);
    @(negedge clk);
    idle_inputs();
    tick();
    chk_status("ovf_after", 7'd64, 1'b0);

    // One-byte push with one-byte pop at full is exactly DEPTH: legal.
    @(negedge clk);
    idle_inputs();
    store_tx_data = 1'b1; tx_size = 2'b00; hwdata = 32'h00000055;
    get_tx_packet_data = 1'b1;
    #1;
    chk("full_pushpop_tx", 32'(tx_packet_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h55);
    tick();
    chk_status("full_pushpop", 7'd64, 1'b0);

    // Two-byte push with one-byte pop would reach 65: push dropped, pop kept.
    @(negedge clk);
    idle_inputs();
    store_tx_data = 1'b1; tx_size = 2'b01; hwdata = 32'h0000A5A5;
    get_tx_packet_data = 1'b1;
    #1;
    chk("ovf_pop_tx", 32'(tx_packet_data), 32'(exp_q.pop_front()));
    tick();
    chk_status("ovf_pop", 7'd63, 1'b1);

    while (exp_q.size() > 0) usb_pop_chk($sformatf("drain_%0d", exp_q.size()));
    chk_status("drained", 7'd0, 1'b0);

    // ---- wrap-around: word spanning addresses 62,63,0,1 ----
    do_flush();
    chk_status("flush_wrap", 7'd0, 1'b0);
    for (int i = 0; i < 62; i++) usb_push(8'(8'h80 + i));
    chk_status("push62", 7'd62, 1'b0);
    for (int i = 0; i < 31; i++) begin
      logic [7:0] b0, b1;
      @(negedge clk);
      idle_inputs();
      get_rx_data = 1'b1; rx_size = 2'b01;
      b0 = exp_q.pop_front();
      b1 = exp_q.pop_front();
      #1;
      chk($sformatf("half_pop_%0d", i), rx_data, {16'h0, b1, b0});
      tick();
    end
    chk_status("pop62", 7'd0, 1'b0);
    @(negedge clk);
    idle_inputs();
    store_tx_data = 1'b1; tx_size = 2'b10; hwdata = 32'h44332211;
    tick();
    chk_status("wrap_push", 7'd4, 1'b0);
    @(negedge clk);
    idle_inputs();
    get_rx_data = 1'b1; rx_size = 2'b10;
    #1;
    chk("wrap_rx_data", rx_data, 32'h44332211);
    tick();
    chk_status("wrap_pop", 7'd0, 1'b0);

    // ---- occupancy 20 then flush with a concurrent push ----
    for (int i = 0; i < 20; i++) usb_push(8'(i));
    chk_status("occ20", 7'd20, 1'b0);
    @(negedge clk);
    idle_inputs();
    flush = 1'b1; store_tx_data = 1'b1; tx_size = 2'b10; hwdata = 32'hDEADBEEF;
    exp_q.delete();
    tick();
    chk_status("flush20", 7'd0, 1'b0);

    // ---- reset during back-to-back pushes ----
    @(negedge clk);
    idle_inputs();
    store_tx_data = 1'b1; tx_size = 2'b10; hwdata = 32'h12345678;
    tick();
    tick();
    chk_status("b2b_push", 7'd8, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    tick();
    chk_status("rst_mid", 7'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    hwdata = 32'hCAFEBABE;
    tick();
    chk_status("rst_first", 7'd4, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst_first_rx", rx_data, 32'hCAFEBABE);
    tick();

`ifdef USB_DATA_BUFFER_WATERMARK_EN
    // ---- watermark ----
    do_flush();
    for (int i = 0; i < 55; i++) usb_push(8'(i));
    chk("af_55", 32'(almost_full), 32'h0);
    usb_push(8'h37);
    chk("af_56", 32'(almost_full), 32'h1);
    chk_status("af_occ56", 7'd56, 1'b0);
    usb_pop_chk("af_pop");
    chk("af_55_again", 32'(almost_full), 32'h0);
`endif

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
